// File: rtl/muldiv_pkg.sv
// Shared types, constants and helpers for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [3:0] {
        MD_MULT  = 4'd0,
        MD_MULTU = 4'd1,
        MD_DIV   = 4'd2,
        MD_DIVU  = 4'd3,
        MD_MADD  = 4'd4,
        MD_MADDU = 4'd5,
        MD_MSUB  = 4'd6,
        MD_MSUBU = 4'd7,
        MD_MTHI  = 4'd8,
        MD_MTLO  = 4'd9
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } muldiv_state_t;

    localparam int DIV_ITERS = 32;

    // Signed flavours sign-extend their operands; the rest zero-extend.
    function automatic logic op_is_signed(input muldiv_op_t o);
        return (o == MD_MULT) || (o == MD_DIV) || (o == MD_MADD) || (o == MD_MSUB);
    endfunction

    // Absolute value for signed operands, pass-through for unsigned ones.
    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (32'd0 - v) : v;
    endfunction

    // Product of the 33-bit extended operands, kept modulo 2^64.
    function automatic logic [63:0] mul33(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = {{32{sgn & a[31]}}, a};
        eb = {{32{sgn & b[31]}}, b};
        return ea * eb;
    endfunction

endpackage

// File: rtl/muldiv_sequencer_div_step.sv
// One iteration of a radix-2 restoring divider: shift in the next dividend
// bit, try to subtract the divisor, keep the result only if it did not go negative.
module div_step (
    input  logic [32:0] rem_i,
    input  logic [31:0] quo_i,
    input  logic [31:0] dvsr_i,
    output logic [32:0] rem_o,
    output logic [31:0] quo_o
);
    logic [32:0] shifted_s;
    logic [33:0] diff_s;
    logic        unused_s;

    // The remainder always stays below the divisor, so its top bit is never needed.
    assign unused_s = rem_i[32];

    // Trial subtraction and restore decision.
    always_comb begin
        shifted_s = {rem_i[31:0], quo_i[31]};
        diff_s    = {1'b0, shifted_s} - {2'b00, dvsr_i};
        if (diff_s[33]) begin
            rem_o = shifted_s;
            quo_o = {quo_i[30:0], 1'b0};
        end else begin
            rem_o = diff_s[32:0];
            quo_o = {quo_i[30:0], 1'b1};
        end
    end
endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide controller owning the architectural HI/LO pair.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int MUL_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic        cancel,
    input  logic        read_hilo,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [5:0] MUL_LAST = 6'(MUL_LATENCY - 1);
    localparam logic [5:0] DIV_LAST = 6'(DIV_ITERS - 1);

    muldiv_state_t state_q, state_d;
    muldiv_op_t    op_q, op_d, op_s;
    logic [5:0]    cnt_q, cnt_d;
    logic [31:0]   rs_q, rs_d, rt_q, rt_d;
    logic [32:0]   rem_q, rem_d;
    logic [31:0]   quo_q, quo_d, dvsr_q, dvsr_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic          done_q, done_d;

    logic [63:0]   prod_s, mul_res_s, acc_s;
    logic [32:0]   step_rem_s;
    logic [31:0]   step_quo_s, fix_quo_s, fix_rem_s;

    assign op_s   = muldiv_op_t'(op);
    assign prod_s = mul33(rs_q, rt_q, op_is_signed(op_q));

    // Multiplier pipe: operands are stable for the whole MUL phase, so the
    // final stage holds the product by the last count.
    generate
        if (MUL_LATENCY > 1) begin : g_pipe
            logic [63:0] pipe_q [MUL_LATENCY-1];
            logic [63:0] pipe_d [MUL_LATENCY-1];

            // Shift the product down the pipe one stage per cycle.
            always_comb begin
                pipe_d[0] = prod_s;
                for (int i = 1; i < MUL_LATENCY - 1; i++) begin
                    pipe_d[i] = pipe_q[i-1];
                end
            end

            // Pipe registers, cleared on reset.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    for (int i = 0; i < MUL_LATENCY - 1; i++) begin
                        pipe_q[i] <= 64'd0;
                    end
                end else begin
                    for (int i = 0; i < MUL_LATENCY - 1; i++) begin
                        pipe_q[i] <= pipe_d[i];
                    end
                end
            end

            assign mul_res_s = pipe_q[MUL_LATENCY-2];
        end else begin : g_nopipe
            assign mul_res_s = prod_s;
        end
    endgenerate

    div_step u_div_step (
        .rem_i  (rem_q),
        .quo_i  (quo_q),
        .dvsr_i (dvsr_q),
        .rem_o  (step_rem_s),
        .quo_o  (step_quo_s)
    );

    // Accumulate variants and divide sign fix-up, evaluated from current HI/LO.
    always_comb begin
        case (op_q)
            MD_MADD, MD_MADDU: acc_s = {hi_q, lo_q} + mul_res_s;
            MD_MSUB, MD_MSUBU: acc_s = {hi_q, lo_q} - mul_res_s;
            default:           acc_s = mul_res_s;
        endcase
        if (op_q == MD_DIV) begin
            fix_quo_s = (rs_q[31] ^ rt_q[31]) ? (32'd0 - quo_q) : quo_q;
            fix_rem_s = rs_q[31] ? (32'd0 - rem_q[31:0]) : rem_q[31:0];
        end else begin
            fix_quo_s = quo_q;
            fix_rem_s = rem_q[31:0];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; cancel always returns to IDLE.
    always_comb begin
        state_d = state_q;
        if (cancel) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    case (op_s)
                        MD_MULT, MD_MULTU, MD_MADD, MD_MADDU,
                        MD_MSUB, MD_MSUBU: state_d = start ? MUL : IDLE;
                        MD_DIV, MD_DIVU:   state_d = start ? DIV : IDLE;
                        default:           state_d = IDLE;
                    endcase
                end
                MUL:     state_d = (cnt_q == MUL_LAST) ? IDLE : MUL;
                DIV:     state_d = (cnt_q == DIV_LAST) ? FIX : DIV;
                FIX:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs: busy whenever an op is in flight, stall on any collision with it.
    always_comb begin
        busy  = (state_q != IDLE);
        stall = (state_q != IDLE) && (start || read_hilo);
    end

    // Datapath next values: operand latching, iteration and HI/LO writes.
    always_comb begin
        cnt_d  = cnt_q;
        op_d   = op_q;
        rs_d   = rs_q;
        rt_d   = rt_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvsr_d = dvsr_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        done_d = 1'b0;
        if (cancel) begin
            cnt_d = 6'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        case (op_s)
                            MD_MTHI: hi_d = rs;
                            MD_MTLO: lo_d = rs;
                            default: begin
                                cnt_d  = 6'd0;
                                op_d   = op_s;
                                rs_d   = rs;
                                rt_d   = rt;
                                rem_d  = 33'd0;
                                quo_d  = magnitude(rs, op_s == MD_DIV);
                                dvsr_d = magnitude(rt, op_s == MD_DIV);
                            end
                        endcase
                    end else begin
                        cnt_d = 6'd0;
                    end
                end
                MUL: begin
                    if (cnt_q == MUL_LAST) begin
                        {hi_d, lo_d} = acc_s;
                        done_d       = 1'b1;
                        cnt_d        = 6'd0;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
                DIV: begin
                    rem_d = step_rem_s;
                    quo_d = step_quo_s;
                    cnt_d = (cnt_q == DIV_LAST) ? 6'd0 : (cnt_q + 6'd1);
                end
                FIX: begin
                    lo_d   = fix_quo_s;
                    hi_d   = fix_rem_s;
                    done_d = 1'b1;
                    cnt_d  = 6'd0;
                end
                default: cnt_d = 6'd0;
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q  <= 6'd0;
            op_q   <= MD_MULT;
            rs_q   <= 32'd0;
            rt_q   <= 32'd0;
            rem_q  <= 33'd0;
            quo_q  <= 32'd0;
            dvsr_q <= 32'd0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            op_q   <= op_d;
            rs_q   <= rs_d;
            rt_q   <= rt_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvsr_q <= dvsr_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            done_q <= done_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign done = done_q;

endmodule
